fft_mem_arbiter: RTL
====================

# fft_mem_arbiter

Shares the single 4-entry sample memory (`fft_memory`: one write port, two read ports) among three requesters: the host loader, the FFT sequencer, and the output reader. It grants ownership in round-robin order, supports locked multi-cycle bursts, and forwards the owner's access to the memory. It routes `read_valid` and read data back to the requester that issued the read. It sits between the top-level control FSMs and `fft_memory`.

## Interface
- `NREQ`, 3, number of requesters (0 = load, 1 = FFT, 2 = output)
- `AW`, 2, memory address width
- `DW`, 16, memory data width
- `TIMEOUT`, 64, grant watchdog limit in cycles; used only with `ARB_TIMEOUT_EN`

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `req`  in  NREQ  per-requester ownership request, level
- `lock`  in  NREQ  hold grant across cycles while `req` is high
- `we`, `re`  in  NREQ  write / read strobes; honoured only from the owner
- `addr_w`  in  NREQ×AW  write address per requester
- `wdata`  in  NREQ×DW  write data per requester
- `addr_a`, `addr_b`  in  NREQ×AW  read addresses per requester
- `gnt`  out  NREQ  one-hot or zero grant, registered
- `rvalid`  out  NREQ  one-hot read-data-valid, routed to the issuing requester
- `rdata_a`, `rdata_b`  out  DW  shared read data, qualified by `rvalid`
- `viol`  out  1  sticky flag: non-owner asserted `we` or `re`
- `timeout_err`  out  1  sticky watchdog flag
- `mem_en`, `mem_read_en`, `mem_write_en`  out  1  to `fft_memory`
- `mem_addr_w`, `mem_addr_a`, `mem_addr_b`  out  AW  to `fft_memory`
- `mem_data_in`  out  DW  to `fft_memory`
- `mem_data_out_a`, `mem_data_out_b`  in  DW  from `fft_memory`
- `mem_read_valid`  in  1  from `fft_memory`; high exactly 1 cycle after `mem_read_en`

## Operation
- State: `owner` (index) plus `busy` bit; `last` holds the most recent owner for rotation.
- Idle (`busy=0`) with any `req` high: the next owner is the first requester with `req` high, searching `last+1`, `last+2`, … modulo NREQ.
  - The grant is registered.
  - `busy` is set and `gnt[owner]` is high from the next edge.
- Owner with `lock` high and `req` high: grant held.
- Owner with `lock` low: grant lasts exactly one cycle.
  - The owner then re-arbitrates against the others.
  - It rotates to the back of the order.
- Owner drops `req`: the grant is released at the next edge.
  - If another `req` is pending, the new `gnt` rises at that same edge, so there is no idle cycle.
- Memory forwarding is combinational from the owner's inputs, gated by `gnt[owner]`:
  - `mem_write_en = we[owner]`
  - `mem_read_en = re[owner]`
  - `mem_en = mem_write_en | mem_read_en`
- Non-owner `we`/`re`:
  - Ignored; no memory effect.
  - Sets `viol` at the next edge; `viol` clears only on reset.
- Read tracking:
  - A 1-deep register `rd_tag` captures `owner` when `mem_read_en` is high.
  - `rvalid[rd_tag] = mem_read_valid`.
  - Delivery is correct even if the grant moves in between.
- `rdata_a`/`rdata_b` pass `mem_data_out_a`/`mem_data_out_b` through.
- Simultaneous `we` and `re` from the owner: both are forwarded in the same cycle.
  - Read-during-write to the same address returns the old data (memory behaviour).

## Timing
- Reset values (at the first edge with `rst` high):
  - `gnt=0`, `busy=0`, `last=NREQ-1` (requester 0 wins first), `rd_tag=0`.
  - `rvalid=0`; any pending read response is dropped.
  - `viol=0`, `timeout_err=0`, all `mem_*` outputs 0.
- Latency:
  - `req` to `gnt`: 1 cycle when free.
  - Access to `rvalid`: 1 cycle.
- Reset mid-burst: the grant is lost immediately; requesters must re-request.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter (width `$clog2(TIMEOUT+1)`) counts consecutive cycles of an unchanged owner.
  - On reaching TIMEOUT, the grant is revoked at the next edge and `timeout_err` is set (sticky).
  - That requester is masked from arbitration until its `req` goes low.
- `ARB_TIMEOUT_EN` undefined: no counter and no mask; `timeout_err` tied 0.

## Structure
- Package `fft_arb_pkg` holds:
  - localparams `REQ_LOAD=0`, `REQ_FFT=1`, `REQ_OUT=2`
  - default `NREQ`/`AW`/`DW`
  - typedef `req_id_t` (logic [$clog2(NREQ)-1:0])
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req` mask, `last`.
  - Outputs: `valid`, `idx`.

## Test plan
- Reset, then `req=3'b001` with `lock=1` → `gnt=3'b001` one cycle later; `we` with addr 2, data 16'h00A5 → `mem_write_en=1`, `mem_addr_w=2`, `mem_data_in=16'h00A5`.
- `req=3'b111` simultaneously, `lock=0` → grants rotate 001, 010, 100, 001 on consecutive cycles.
- Owner 1 issues `re`, addresses a=0, b=1, then drops `req`; requester 2 is granted → `rvalid=3'b010` on the following cycle with the memory data, while `gnt=3'b100`.
- Requester 2 asserts `we` while 0 owns → memory is unchanged and `viol=1` next cycle; it stays 1 until `rst`.
- With `ARB_TIMEOUT_EN`, TIMEOUT=4: requester 0 locks and `req=3'b011` → `gnt` moves to 010 after 4 cycles and `timeout_err=1`; requester 0 is not re-granted until its `req` has toggled low.
- Assert `rst` mid-burst with a read pending → next cycle `gnt=0`, `rvalid=0`, `mem_en=0`.

Source files
------------

// File: rtl/fft_arb_pkg.sv
// fft_mem_arbiter shared types and defaults.
// Requester ids, default geometry and arbiter state encoding.
package fft_arb_pkg;

  localparam int REQ_LOAD = 0;
  localparam int REQ_FFT  = 1;
  localparam int REQ_OUT  = 2;

  localparam int NREQ = 3;
  localparam int AW   = 2;
  localparam int DW   = 16;

  typedef logic [$clog2(NREQ)-1:0] req_id_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

endpackage

// File: rtl/fft_mem_arbiter_if.sv
// Requester-side bus of fft_mem_arbiter.
// master = requester cluster, slave = arbiter.
interface fft_mem_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 2,
  parameter int DW   = 16
) ();

  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         lock;
  logic [NREQ-1:0]         we;
  logic [NREQ-1:0]         re;
  logic [NREQ-1:0][AW-1:0] addr_w;
  logic [NREQ-1:0][DW-1:0] wdata;
  logic [NREQ-1:0][AW-1:0] addr_a;
  logic [NREQ-1:0][AW-1:0] addr_b;
  logic [NREQ-1:0]         gnt;
  logic [NREQ-1:0]         rvalid;
  logic [DW-1:0]           rdata_a;
  logic [DW-1:0]           rdata_b;

  modport master (
    output req, lock, we, re,
    output addr_w, wdata, addr_a, addr_b,
    input  gnt, rvalid, rdata_a, rdata_b
  );

  modport slave (
    input  req, lock, we, re,
    input  addr_w, wdata, addr_a, addr_b,
    output gnt, rvalid, rdata_a, rdata_b
  );

endinterface

// File: rtl/fft_mem_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches last+1, last+2, ... modulo NREQ.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] c;

  always_comb begin
    valid = 1'b0;
    idx   = last;
    c     = last;
    for (int k = 0; k < NREQ; k++) begin
      c = (c == IW'(NREQ - 1)) ? '0 : c + 1'b1;
      if (req[c] && !valid) begin
        valid = 1'b1;
        idx   = c;
      end
    end
  end

endmodule

// File: rtl/fft_mem_arbiter.sv
// Round-robin owner arbiter in front of the 4-entry fft_memory.
// Optional grant watchdog: define ARB_TIMEOUT_EN.
module fft_mem_arbiter #(
  parameter int NREQ = fft_arb_pkg::NREQ,
  parameter int AW   = fft_arb_pkg::AW,
  parameter int DW   = fft_arb_pkg::DW
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic          clk,
  input  logic          rst,
  fft_mem_arbiter_if.slave bus,
  output logic          viol,
  output logic          timeout_err,
  output logic          mem_en,
  output logic          mem_read_en,
  output logic          mem_write_en,
  output logic [AW-1:0] mem_addr_w,
  output logic [AW-1:0] mem_addr_a,
  output logic [AW-1:0] mem_addr_b,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out_a,
  input  logic [DW-1:0] mem_data_out_b,
  input  logic          mem_read_valid
);

  import fft_arb_pkg::*;

  arb_state_t      state, state_n;
  req_id_t         owner, owner_n;
  req_id_t         last, last_n;
  req_id_t         rd_tag;
  logic            rd_pend;
  logic            own;
  logic            hold;
  logic            pick_v;
  req_id_t         pick_i;
  logic [NREQ-1:0] gnt_vec;
  logic [NREQ-1:0] elig;
  logic            to_hit;

  assign own     = (state == ARB_BUSY);
  assign gnt_vec = own ? (NREQ'(1) << owner) : '0;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] tmask;
  logic            to_err;

  assign to_hit      = own && (cnt == CW'(TIMEOUT));
  assign elig        = bus.req & ~tmask & ~(to_hit ? gnt_vec : '0);
  assign timeout_err = to_err;

  // Count cycles of an unchanged owner; restart on any hand-over.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      tmask  <= '0;
      to_err <= 1'b0;
    end else begin
      tmask <= (tmask & bus.req) | (to_hit ? gnt_vec : '0);
      if (to_hit)
        to_err <= 1'b1;
      if (state_n != ARB_BUSY)
        cnt <= '0;
      else if (!own || owner_n != owner)
        cnt <= CW'(1);
      else
        cnt <= cnt + 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign elig        = bus.req;
  assign timeout_err = 1'b0;
`endif

  assign hold = own && bus.req[owner] &&
                bus.lock[owner] && !to_hit;

  rr_pick #(
    .NREQ (NREQ),
    .IW   ($bits(req_id_t))
  ) u_pick (
    .req   (elig),
    .last  (last),
    .valid (pick_v),
    .idx   (pick_i)
  );

  // last tracks the current owner, so a released owner goes to the back.
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    if (!hold) begin
      if (pick_v) begin
        state_n = ARB_BUSY;
        owner_n = pick_i;
        last_n  = pick_i;
      end else begin
        state_n = ARB_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      owner   <= '0;
      last    <= req_id_t'(NREQ - 1);
      rd_tag  <= '0;
      rd_pend <= 1'b0;
      viol    <= 1'b0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      last    <= last_n;
      rd_pend <= mem_read_en;
      if (mem_read_en)
        rd_tag <= owner;
      if (|((bus.we | bus.re) & ~gnt_vec))
        viol <= 1'b1;
    end
  end

  assign mem_write_en = own & bus.we[owner];
  assign mem_read_en  = own & bus.re[owner];
  assign mem_en       = mem_write_en | mem_read_en;
  assign mem_addr_w   = own ? bus.addr_w[owner] : '0;
  assign mem_addr_a   = own ? bus.addr_a[owner] : '0;
  assign mem_addr_b   = own ? bus.addr_b[owner] : '0;
  assign mem_data_in  = own ? bus.wdata[owner]  : '0;

  assign bus.gnt     = gnt_vec;
  assign bus.rvalid  = (rd_pend & mem_read_valid) ?
                       (NREQ'(1) << rd_tag) : '0;
  assign bus.rdata_a = mem_data_out_a;
  assign bus.rdata_b = mem_data_out_b;

endmodule
